// File: rtl/serdes_prbs31_checker_pkg.sv
// Shared constants and state encoding for the PRBS31 (x^31 + x^28 + 1) block checker.
package serdes_prbs31_checker_pkg;

    // Feedback taps into the history register (hist[0] is the newest bit).
    localparam int unsigned PRBS31_TAP_A = 27;
    localparam int unsigned PRBS31_TAP_B = 30;

    // One 64b/66b block: 2 header bits followed by 64 payload bits.
    localparam int unsigned BLOCK_BITS = 66;
    localparam int unsigned HIST_BITS  = 31;
    localparam int unsigned ERR_BITS_W = 7;

    typedef enum logic {
        CHK_SEEK   = 1'b0,
        CHK_LOCKED = 1'b1
    } chk_state_e;

endpackage

// File: rtl/prbs31_block_check.sv
// Combinational PRBS31 self-synchronising check of one 66-bit block.
// Each received bit is compared against the prediction from the history, then shifted
// into the history before the next bit is checked. Also reused by the TX generator bench.
module prbs31_block_check
    import serdes_prbs31_checker_pkg::*;
(
    input  logic [HIST_BITS-1:0]  hist_in,
    input  logic [BLOCK_BITS-1:0] bits,
    output logic [HIST_BITS-1:0]  hist_out,
    output logic [ERR_BITS_W-1:0] err_bits
);

    logic [HIST_BITS-1:0] h;
    logic                 e;

    // Walk the block in serial order, accumulating the popcount of error bits.
    always_comb begin
        h        = hist_in;
        e        = 1'b0;
        err_bits = '0;
        for (int i = 0; i < BLOCK_BITS; i++) begin
            e        = bits[i] ^ h[PRBS31_TAP_A] ^ h[PRBS31_TAP_B];
            err_bits = err_bits + ERR_BITS_W'(e);
            h        = {h[HIST_BITS-2:0], bits[i]};
        end
        hist_out = h;
    end

endmodule

// File: rtl/serdes_prbs31_checker.sv
// PRBS31 checker for the 64b/66b SerDes stream: lock FSM, error and block counters.
// Optional feature macro SERDES_PRBS31_CHK_BLOCK_CNT_EN builds the locked-block counter;
// without it stat_block_count is tied to zero.
module serdes_prbs31_checker
    import serdes_prbs31_checker_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 64,
    parameter int unsigned HDR_WIDTH     = 2,
    parameter int unsigned LOCK_COUNT    = 4,
    parameter int unsigned UNLOCK_COUNT  = 16,
    parameter int unsigned ERR_CNT_WIDTH = 32,
    parameter int unsigned PRBS_INVERT   = 0
) (
    input  logic                     rx_clk,
    input  logic                     rx_rst,
    input  logic [DATA_WIDTH-1:0]    in_data,
    input  logic [HDR_WIDTH-1:0]     in_hdr,
    input  logic                     in_valid,
    input  logic                     cfg_enable,
    input  logic                     cfg_clear_count,
    output logic                     prbs_locked,
    output logic                     block_error,
    output logic [ERR_CNT_WIDTH-1:0] err_count,
    output logic [31:0]              stat_block_count
);

    localparam int unsigned CntMax = (LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    chk_state_e              state_q, state_d;
    logic [CntW-1:0]         lock_cnt_q, lock_cnt_d;
    logic [CntW-1:0]         unlock_cnt_q, unlock_cnt_d;
    logic [HIST_BITS-1:0]    hist_q, hist_d, hist_next;
    logic                    first_q, first_d;
    logic                    block_error_q, block_error_d;
    logic [ERR_CNT_WIDTH-1:0] err_count_q, err_count_d, err_base;
    logic [ERR_CNT_WIDTH:0]  err_sum;
    logic [BLOCK_BITS-1:0]   raw_bits, blk_bits;
    logic [ERR_BITS_W-1:0]   blk_err_bits;
    logic                    blk_clean;
    logic                    count_en;

    // Header goes first on the wire, so it occupies the low bits of the serial vector.
    assign raw_bits = BLOCK_BITS'({in_data, in_hdr});
    assign blk_bits = (PRBS_INVERT != 0) ? ~raw_bits : raw_bits;

    prbs31_block_check u_block_check (
        .hist_in  (hist_q),
        .bits     (blk_bits),
        .hist_out (hist_next),
        .err_bits (blk_err_bits)
    );

    // The first block after reset is checked against an empty history, so it never counts as clean.
    assign blk_clean = (blk_err_bits == '0) && !first_q;

    // Next-state: lock FSM, history, block_error and the error counter.
    always_comb begin
        state_d       = state_q;
        lock_cnt_d    = lock_cnt_q;
        unlock_cnt_d  = unlock_cnt_q;
        hist_d        = hist_q;
        first_d       = first_q;
        block_error_d = block_error_q;
        count_en      = 1'b0;

        if (in_valid) begin
            hist_d  = hist_next;
            first_d = 1'b0;
        end

        if (!cfg_enable) begin
            state_d      = CHK_SEEK;
            lock_cnt_d   = '0;
            unlock_cnt_d = '0;
            if (in_valid) begin
                block_error_d = 1'b0;
            end
        end else if (in_valid) begin
            unique case (state_q)
                CHK_SEEK: begin
                    block_error_d = 1'b0;
                    if (blk_clean) begin
                        if (lock_cnt_q + CntW'(1) == CntW'(LOCK_COUNT)) begin
                            state_d      = CHK_LOCKED;
                            lock_cnt_d   = '0;
                            unlock_cnt_d = '0;
                        end else begin
                            lock_cnt_d = lock_cnt_q + CntW'(1);
                        end
                    end else begin
                        lock_cnt_d = '0;
                    end
                end
                CHK_LOCKED: begin
                    count_en      = 1'b1;
                    block_error_d = (blk_err_bits != '0);
                    if (blk_err_bits != '0) begin
                        if (unlock_cnt_q + CntW'(1) == CntW'(UNLOCK_COUNT)) begin
                            state_d      = CHK_SEEK;
                            unlock_cnt_d = '0;
                            lock_cnt_d   = '0;
                        end else begin
                            unlock_cnt_d = unlock_cnt_q + CntW'(1);
                        end
                    end else begin
                        unlock_cnt_d = '0;
                    end
                end
            endcase
        end

        // Clear takes effect first, then any increment from the same block is added.
        err_base    = cfg_clear_count ? '0 : err_count_q;
        err_sum     = {1'b0, err_base} + (ERR_CNT_WIDTH + 1)'(blk_err_bits);
        err_count_d = err_base;
        if (count_en) begin
            err_count_d = err_sum[ERR_CNT_WIDTH] ? '1 : err_sum[ERR_CNT_WIDTH-1:0];
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge rx_clk) begin
        if (rx_rst) begin
            state_q       <= CHK_SEEK;
            lock_cnt_q    <= '0;
            unlock_cnt_q  <= '0;
            hist_q        <= '0;
            first_q       <= 1'b1;
            block_error_q <= 1'b0;
            err_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            lock_cnt_q    <= lock_cnt_d;
            unlock_cnt_q  <= unlock_cnt_d;
            hist_q        <= hist_d;
            first_q       <= first_d;
            block_error_q <= block_error_d;
            err_count_q   <= err_count_d;
        end
    end

    assign prbs_locked = (state_q == CHK_LOCKED);
    assign block_error = block_error_q;
    assign err_count   = err_count_q;

`ifdef SERDES_PRBS31_CHK_BLOCK_CNT_EN
    logic [31:0] blk_cnt_q, blk_cnt_d, blk_base;

    // Saturating count of blocks accepted while locked, same clear-then-add rule as err_count.
    always_comb begin
        blk_base  = cfg_clear_count ? '0 : blk_cnt_q;
        blk_cnt_d = blk_base;
        if (count_en && (blk_base != 32'hFFFF_FFFF)) begin
            blk_cnt_d = blk_base + 32'd1;
        end
    end

    // Block counter register.
    always_ff @(posedge rx_clk) begin
        if (rx_rst) begin
            blk_cnt_q <= '0;
        end else begin
            blk_cnt_q <= blk_cnt_d;
        end
    end

    assign stat_block_count = blk_cnt_q;
`else
    assign stat_block_count = 32'd0;
`endif

endmodule

// File: tb/tb_serdes_prbs31_checker.sv
// Directed bench for serdes_prbs31_checker (ERR_CNT_WIDTH=8 so saturation is reachable).
module tb_serdes_prbs31_checker;

    localparam int EW      = 8;
    localparam int M_IDLE  = 0;
    localparam int M_CLEAN = 1;
    localparam int M_FLIP  = 2;
    localparam int M_ALLER = 3;
    localparam int M_RAND  = 4;

    logic          clk = 1'b0;
    logic          rx_rst;
    logic [63:0]   in_data;
    logic [1:0]    in_hdr;
    logic          in_valid;
    logic          cfg_enable;
    logic          cfg_clear_count;
    logic          prbs_locked;
    logic          block_error;
    logic [EW-1:0] err_count;
    logic [31:0]   stat_block_count;

    int checks = 0;
    int errors = 0;

    // History of the transmitted stream (bit 0 newest).
    logic [30:0] tx_h;

    typedef struct {
        int         mode;
        logic       clear;
        logic       locked;
        logic       berr;
        logic [7:0] ecnt;
    } vec_t;

    vec_t tbl[17];

    always #5 clk = ~clk;

    serdes_prbs31_checker #(
        .ERR_CNT_WIDTH (EW)
    ) dut (
        .rx_clk           (clk),
        .rx_rst           (rx_rst),
        .in_data          (in_data),
        .in_hdr           (in_hdr),
        .in_valid         (in_valid),
        .cfg_enable       (cfg_enable),
        .cfg_clear_count  (cfg_clear_count),
        .prbs_locked      (prbs_locked),
        .block_error      (block_error),
        .err_count        (err_count),
        .stat_block_count (stat_block_count)
    );

    // inv=0: clean PRBS31 continuation; inv=1: every bit mispredicted.
    function automatic logic [65:0] gen_block(input logic [30:0] h_in, input logic inv);
        logic [30:0] h;
        logic [65:0] b;
        h = h_in;
        for (int i = 0; i < 66; i++) begin
            b[i] = h[27] ^ h[30] ^ inv;
            h    = {h[29:0], b[i]};
        end
        return b;
    endfunction

    function automatic logic [30:0] shift_hist(input logic [30:0] h_in, input logic [65:0] b);
        logic [30:0] h;
        h = h_in;
        for (int i = 0; i < 66; i++) h = {h[29:0], b[i]};
        return h;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle; outputs are sampled 1 time unit after the edge.
    task automatic step(input int mode, input logic clear);
        logic [65:0] b;
        logic [65:0] flip;
        flip = 66'd1 << 12;  // data bit 10
        case (mode)
            M_CLEAN: b = gen_block(tx_h, 1'b0);
            M_FLIP:  b = gen_block(tx_h, 1'b0) ^ flip;
            M_ALLER: b = gen_block(tx_h, 1'b1);
            default: b = {$urandom(), $urandom(), 2'b00};
        endcase
        {in_data, in_hdr} = b;
        in_valid          = (mode != M_IDLE);
        cfg_clear_count   = clear;
        @(posedge clk);
        #1;
        if (mode != M_IDLE) tx_h = shift_hist(tx_h, b);
        in_valid        = 1'b0;
        cfg_clear_count = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{M_CLEAN, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[1]  = '{M_CLEAN, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[2]  = '{M_CLEAN, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[3]  = '{M_CLEAN, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[4]  = '{M_CLEAN, 1'b0, 1'b1, 1'b0, 8'd0};
        tbl[5]  = '{M_IDLE,  1'b0, 1'b1, 1'b0, 8'd0};
        tbl[6]  = '{M_FLIP,  1'b0, 1'b1, 1'b1, 8'd3};
        tbl[7]  = '{M_IDLE,  1'b0, 1'b1, 1'b1, 8'd3};
        tbl[8]  = '{M_CLEAN, 1'b0, 1'b1, 1'b0, 8'd3};
        tbl[9]  = '{M_ALLER, 1'b0, 1'b1, 1'b1, 8'd69};
        tbl[10] = '{M_ALLER, 1'b0, 1'b1, 1'b1, 8'd135};
        tbl[11] = '{M_ALLER, 1'b0, 1'b1, 1'b1, 8'd201};
        tbl[12] = '{M_ALLER, 1'b0, 1'b1, 1'b1, 8'd255};
        tbl[13] = '{M_CLEAN, 1'b0, 1'b1, 1'b0, 8'd255};
        tbl[14] = '{M_FLIP,  1'b1, 1'b1, 1'b1, 8'd3};
        tbl[15] = '{M_IDLE,  1'b1, 1'b1, 1'b1, 8'd0};
        tbl[16] = '{M_CLEAN, 1'b0, 1'b1, 1'b0, 8'd0};

        tx_h            = 31'h7FFF_FFFF;
        rx_rst          = 1'b1;
        in_data         = '0;
        in_hdr          = '0;
        in_valid        = 1'b0;
        cfg_enable      = 1'b1;
        cfg_clear_count = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rx_rst = 1'b0;
        chk("rst_locked", 64'(prbs_locked), 64'd0);
        chk("rst_berr", 64'(block_error), 64'd0);
        chk("rst_ecnt", 64'(err_count), 64'd0);
        chk("rst_stat", 64'(stat_block_count), 64'd0);

        // Lock, single-bit error with echoes, saturation, clear-with-add.
        for (int i = 0; i < 17; i++) begin
            step(tbl[i].mode, tbl[i].clear);
            chk($sformatf("vec%0d_locked", i), 64'(prbs_locked), 64'(tbl[i].locked));
            chk($sformatf("vec%0d_berr", i), 64'(block_error), 64'(tbl[i].berr));
            chk($sformatf("vec%0d_ecnt", i), 64'(err_count), 64'(tbl[i].ecnt));
        end

        // Long clean run keeps err_count at zero.
        for (int i = 0; i < 1000; i++) begin
            step(M_CLEAN, 1'b0);
            chk("clean_run_ecnt", 64'(err_count), 64'd0);
        end
        chk("clean_run_locked", 64'(prbs_locked), 64'd1);

        // 15 errored blocks do not unlock; a clean block resets the run.
        for (int i = 0; i < 15; i++) begin
            step(M_RAND, 1'b0);
            chk("rand15_locked", 64'(prbs_locked), 64'd1);
        end
        step(M_CLEAN, 1'b0);
        chk("rand15_clean_berr", 64'(block_error), 64'd0);
        for (int i = 0; i < 16; i++) begin
            step(M_RAND, 1'b0);
            chk("rand16_locked", 64'(prbs_locked), 64'(i < 15));
        end
        chk("unlock_block_berr", 64'(block_error), 64'd1);

        // Relock needs exactly LOCK_COUNT clean blocks.
        for (int i = 0; i < 4; i++) begin
            step(M_CLEAN, 1'b0);
            chk("relock_locked", 64'(prbs_locked), 64'(i == 3));
        end

        // Disable forces SEEK and freezes counting.
        step(M_IDLE, 1'b1);
        chk("clear_ecnt", 64'(err_count), 64'd0);
        cfg_enable = 1'b0;
        step(M_ALLER, 1'b0);
        chk("dis_locked", 64'(prbs_locked), 64'd0);
        chk("dis_ecnt", 64'(err_count), 64'd0);
        chk("dis_berr", 64'(block_error), 64'd0);
        cfg_enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(M_CLEAN, 1'b0);
            chk("en_relock", 64'(prbs_locked), 64'(i == 3));
        end

        // Mid-stream reset, then relock after LOCK_COUNT+1 blocks with valid gaps.
        step(M_FLIP, 1'b0);
        chk("pre_rst_ecnt", 64'(err_count), 64'd3);
        rx_rst = 1'b1;
        step(M_CLEAN, 1'b0);
        rx_rst = 1'b0;
        chk("midrst_locked", 64'(prbs_locked), 64'd0);
        chk("midrst_berr", 64'(block_error), 64'd0);
        chk("midrst_ecnt", 64'(err_count), 64'd0);
        chk("midrst_stat", 64'(stat_block_count), 64'd0);
        for (int i = 0; i < 5; i++) begin
            for (int g = 0; g < i % 4; g++) step(M_IDLE, 1'b0);
            step(M_CLEAN, 1'b0);
            chk("gap_relock", 64'(prbs_locked), 64'(i == 4));
        end
        chk("gap_ecnt", 64'(err_count), 64'd0);

        // Locked block counter.
        step(M_IDLE, 1'b1);
        for (int i = 0; i < 100; i++) step(M_CLEAN, 1'b0);
`ifdef SERDES_PRBS31_CHK_BLOCK_CNT_EN
        chk("stat_100", 64'(stat_block_count), 64'd100);
`else
        chk("stat_tied", 64'(stat_block_count), 64'd0);
`endif
        chk("stat_run_locked", 64'(prbs_locked), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
